// File: rtl/ps2_scancode_decoder.sv
// PS/2 scan-code-set-2 decoder: strips E0/F0/E1 prefixes, filters status bytes, queues key events.
// Build macro PS2_FAKE_SHIFT_FILTER_EN discards extended fake-shift codes (0x12 / 0x59).
module ps2_scancode_decoder #(
    parameter int DEPTH          = 8,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [7:0]             byte_in,
    input  logic                   byte_valid,
    output logic [7:0]             evt_code,
    output logic                   evt_break,
    output logic                   evt_ext,
    output logic                   evt_valid,
    input  logic                   evt_ready,
    output logic [$clog2(DEPTH):0] evt_count,
    output logic                   overflow,
    input  logic                   ovf_clr,
    output logic                   bat_ok,
    output logic                   kbd_err
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [TMO_W-1:0] TMO_ZERO = TMO_W'(0);
    localparam logic [TMO_W-1:0] TMO_ONE  = TMO_W'(1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_E0    = 3'd1,
        ST_F0    = 3'd2,
        ST_E0F0  = 3'd3,
        ST_PAUSE = 3'd4
    } state_t;

    state_t            state_r, state_nxt_s;
    logic [2:0]        skip_r, skip_nxt_s;
    logic [TMO_W-1:0]  tmo_r, tmo_nxt_s;
    logic              push_s, push_ok_s, fake_s, is_err_s;
    logic [7:0]        push_code_s;
    logic              push_brk_s, push_ext_s;
    logic              bat_s, err_s;
    logic              bat_r, err_r, ovf_r;

    // Event entry layout: {code[7:0], break, ext}
    logic [9:0]        mem_r [DEPTH];
    logic [9:0]        new_evt_s, head_r, head_nxt_s;
    logic [PTR_W-1:0]  wr_ptr_r, rd_ptr_r, rd_nxt_s;
    logic [CNT_W-1:0]  count_r, count_nxt_s;
    logic              valid_r, pop_s, full_s, wr_en_s, drop_s;

    assign is_err_s  = (byte_in == 8'h00) || (byte_in == 8'hFF);
    assign new_evt_s = {push_code_s, push_brk_s, push_ext_s};

    // Prefix FSM next-state, event generation and prefix timeout
    always_comb begin
        state_nxt_s = state_r;
        skip_nxt_s  = skip_r;
        tmo_nxt_s   = TMO_ZERO;
        push_s      = 1'b0;
        push_code_s = byte_in;
        push_brk_s  = 1'b0;
        push_ext_s  = 1'b0;
        bat_s       = 1'b0;
        err_s       = 1'b0;
        if (byte_valid) begin
            case (state_r)
                ST_IDLE: begin
                    case (byte_in)
                        8'hE0:               state_nxt_s = ST_E0;
                        8'hF0:               state_nxt_s = ST_F0;
                        8'hE1: begin
                            state_nxt_s = ST_PAUSE;
                            skip_nxt_s  = 3'd7;
                        end
                        8'hAA:               bat_s  = 1'b1;
                        8'h00, 8'hFF, 8'hFC: err_s  = 1'b1;
                        8'hFA, 8'hEE, 8'hFE: push_s = 1'b0;
                        default:             push_s = 1'b1;
                    endcase
                end
                ST_E0: begin
                    state_nxt_s = ST_IDLE;
                    if (byte_in == 8'hF0) begin
                        state_nxt_s = ST_E0F0;
                    end else if (is_err_s) begin
                        err_s = 1'b1;
                    end else begin
                        push_s     = 1'b1;
                        push_ext_s = 1'b1;
                    end
                end
                ST_F0: begin
                    state_nxt_s = ST_IDLE;
                    if (is_err_s) begin
                        err_s = 1'b1;
                    end else begin
                        push_s     = 1'b1;
                        push_brk_s = 1'b1;
                    end
                end
                ST_E0F0: begin
                    state_nxt_s = ST_IDLE;
                    if (is_err_s) begin
                        err_s = 1'b1;
                    end else begin
                        push_s     = 1'b1;
                        push_brk_s = 1'b1;
                        push_ext_s = 1'b1;
                    end
                end
                ST_PAUSE: begin
                    // The whole 8-byte Pause sequence collapses into a single E1 event
                    skip_nxt_s = skip_r - 3'd1;
                    if (skip_r == 3'd1) begin
                        state_nxt_s = ST_IDLE;
                        push_s      = 1'b1;
                        push_code_s = 8'hE1;
                        push_ext_s  = 1'b1;
                    end else begin
                        state_nxt_s = ST_PAUSE;
                    end
                end
                default: state_nxt_s = ST_IDLE;
            endcase
        end else if (state_r != ST_IDLE) begin
            if (tmo_r == TMO_LAST) begin
                state_nxt_s = ST_IDLE;
            end else begin
                tmo_nxt_s = tmo_r + TMO_ONE;
            end
        end else begin
            tmo_nxt_s = TMO_ZERO;
        end
    end

    // Fake-shift suppression on extended events
    always_comb begin
`ifdef PS2_FAKE_SHIFT_FILTER_EN
        fake_s = push_ext_s && ((push_code_s == 8'h12) || (push_code_s == 8'h59));
`else
        fake_s = 1'b0;
`endif
        push_ok_s = push_s && !fake_s;
    end

    // FIFO control and next head-of-queue view
    always_comb begin
        pop_s       = valid_r && evt_ready;
        full_s      = (count_r == CNT_FULL);
        wr_en_s     = push_ok_s && (!full_s || pop_s);
        drop_s      = push_ok_s && full_s && !pop_s;
        rd_nxt_s    = rd_ptr_r + PTR_ONE;
        count_nxt_s = count_r + {{(CNT_W-1){1'b0}}, wr_en_s} - {{(CNT_W-1){1'b0}}, pop_s};
        head_nxt_s  = head_r;
        // A push lands at the head when the queue is (or is about to become) empty
        if (wr_en_s && (count_r == (pop_s ? CNT_ONE : CNT_ZERO))) begin
            head_nxt_s = new_evt_s;
        end else if (pop_s && (count_r > CNT_ONE)) begin
            head_nxt_s = mem_r[rd_nxt_s];
        end else begin
            head_nxt_s = head_r;
        end
    end

    // Decoder state, timeout counter, status pulses and sticky overflow
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            skip_r  <= 3'd0;
            tmo_r   <= TMO_ZERO;
            bat_r   <= 1'b0;
            err_r   <= 1'b0;
            ovf_r   <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            skip_r  <= skip_nxt_s;
            tmo_r   <= tmo_nxt_s;
            bat_r   <= bat_s;
            err_r   <= err_s;
            if (drop_s) begin
                ovf_r <= 1'b1;
            end else if (ovf_clr) begin
                ovf_r <= 1'b0;
            end else begin
                ovf_r <= ovf_r;
            end
        end
    end

    // FIFO pointers, occupancy and registered head outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= CNT_ZERO;
            head_r   <= 10'd0;
            valid_r  <= 1'b0;
        end else begin
            if (wr_en_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_nxt_s;
            end
            count_r <= count_nxt_s;
            head_r  <= head_nxt_s;
            valid_r <= (count_nxt_s != CNT_ZERO);
        end
    end

    // FIFO storage
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem_r[wr_ptr_r] <= new_evt_s;
        end
    end

    assign evt_code  = head_r[9:2];
    assign evt_break = head_r[1];
    assign evt_ext   = head_r[0];
    assign evt_valid = valid_r;
    assign evt_count = count_r;
    assign overflow  = ovf_r;
    assign bat_ok    = bat_r;
    assign kbd_err   = err_r;
endmodule

// File: tb/tb_ps2_scancode_decoder.sv
// Bench for ps2_scancode_decoder: directed vector table, multi-cycle corner sequences,
// and randomized traffic against a prefix-queue reference model.
module tb_ps2_scancode_decoder;
    localparam int DEPTH = 8;
    localparam int TMO   = 16;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic [7:0]    byte_in = 8'h00;
    logic          byte_valid = 1'b0;
    logic          evt_ready = 1'b0;
    logic          ovf_clr = 1'b0;
    logic [7:0]    evt_code;
    logic          evt_break, evt_ext, evt_valid, overflow, bat_ok, kbd_err;
    logic [CW-1:0] evt_count;

    ps2_scancode_decoder #(.DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst_n(rst_n), .byte_in(byte_in), .byte_valid(byte_valid),
        .evt_code(evt_code), .evt_break(evt_break), .evt_ext(evt_ext),
        .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_count(evt_count),
        .overflow(overflow), .ovf_clr(ovf_clr), .bat_ok(bat_ok), .kbd_err(kbd_err)
    );

    always #5 clk = ~clk;

    int pass_cnt = 0;
    int total_cnt = 0;
    int bat_seen = 0;
    int err_seen = 0;
    bit rnd_chk = 1'b0;

    // Reference model: pending prefix bytes plus an event queue
    logic [7:0] pfx [$];
    logic [9:0] mq [$];
    int         m_idle = 0;
    logic [9:0] m_head = 10'd0;
    bit         m_ovf = 1'b0, m_bat = 1'b0, m_err = 1'b0;

    typedef struct packed {
        logic [63:0] b;
        int          n;
        int          cnt;
        logic [9:0]  e0;
        logic [9:0]  e1;
        int          bat;
        int          err;
    } vec_t;
    vec_t tbl [10];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act !== exp) $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        else pass_cnt++;
    endtask

    task automatic model_reset();
        pfx.delete();
        mq.delete();
        m_idle = 0;
        m_head = 10'd0;
        m_ovf = 1'b0;
        m_bat = 1'b0;
        m_err = 1'b0;
    endtask

    task automatic model_step();
        bit have, bat, err, pop, drop;
        logic [9:0] ev;
        int sz;
        have = 1'b0; bat = 1'b0; err = 1'b0; drop = 1'b0; ev = 10'd0;
        sz = mq.size();
        if (byte_valid) begin
            m_idle = 0;
            if (pfx.size() == 0) begin
                if (byte_in == 8'hE0 || byte_in == 8'hF0 || byte_in == 8'hE1) pfx.push_back(byte_in);
                else if (byte_in == 8'hAA) bat = 1'b1;
                else if (byte_in == 8'h00 || byte_in == 8'hFF || byte_in == 8'hFC) err = 1'b1;
                else if (byte_in == 8'hFA || byte_in == 8'hEE || byte_in == 8'hFE) have = 1'b0;
                else begin have = 1'b1; ev = {byte_in, 2'b00}; end
            end else if (pfx[0] == 8'hE1) begin
                pfx.push_back(byte_in);
                if (pfx.size() == 8) begin
                    have = 1'b1; ev = {8'hE1, 2'b01}; pfx.delete();
                end
            end else if (pfx.size() == 1 && pfx[0] == 8'hE0 && byte_in == 8'hF0) begin
                pfx.push_back(byte_in);
            end else begin
                if (byte_in == 8'h00 || byte_in == 8'hFF) err = 1'b1;
                else begin
                    have = 1'b1;
                    ev = {byte_in, pfx[pfx.size()-1] == 8'hF0, pfx[0] == 8'hE0};
                end
                pfx.delete();
            end
        end else if (pfx.size() != 0) begin
            m_idle++;
            if (m_idle == TMO) begin pfx.delete(); m_idle = 0; end
        end
`ifdef PS2_FAKE_SHIFT_FILTER_EN
        if (have && ev[0] && (ev[9:2] == 8'h12 || ev[9:2] == 8'h59)) have = 1'b0;
`endif
        pop = (sz != 0) && evt_ready;
        if (pop) void'(mq.pop_front());
        if (have) begin
            if (sz == DEPTH && !pop) drop = 1'b1;
            else mq.push_back(ev);
        end
        if (drop) m_ovf = 1'b1;
        else if (ovf_clr) m_ovf = 1'b0;
        if (mq.size() != 0) m_head = mq[0];
        m_bat = bat;
        m_err = err;
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        if (bat_ok) bat_seen++;
        if (kbd_err) err_seen++;
        if (rnd_chk) begin
            chk("r_valid", 32'(evt_valid), 32'(mq.size() != 0));
            chk("r_count", 32'(evt_count), 32'(mq.size()));
            chk("r_head", 32'({evt_code, evt_break, evt_ext}), 32'(m_head));
            chk("r_flags", 32'({overflow, bat_ok, kbd_err}), 32'({m_ovf, m_bat, m_err}));
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        byte_in = b; byte_valid = 1'b1;
        cycle();
        byte_valid = 1'b0;
        cycle();
    endtask

    task automatic drain();
        evt_ready = 1'b1;
        repeat (DEPTH + 2) cycle();
        evt_ready = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; byte_valid = 1'b0; evt_ready = 1'b0; ovf_clr = 1'b0;
        model_reset();
        #1;
        chk("rst_valid", 32'(evt_valid), 32'd0);
        chk("rst_count", 32'(evt_count), 32'd0);
        chk("rst_head", 32'({evt_code, evt_break, evt_ext}), 32'd0);
        chk("rst_flags", 32'({overflow, bat_ok, kbd_err}), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] pool [13];
        logic [7:0] exp_codes [8];
        bit stall;
        pool = '{8'hE0, 8'hF0, 8'hE1, 8'hAA, 8'h00, 8'hFF, 8'hFC, 8'hFA, 8'hEE, 8'hFE, 8'h12, 8'h59, 8'h1C};
        exp_codes = '{8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h0A};

        tbl[0] = '{b:{8'h1C, 8'hF0, 8'h1C, 40'h0}, n:3, cnt:2, e0:{8'h1C, 2'b00}, e1:{8'h1C, 2'b10}, bat:0, err:0};
        tbl[1] = '{b:{8'hE0, 8'h75, 8'hE0, 8'hF0, 8'h75, 24'h0}, n:5, cnt:2, e0:{8'h75, 2'b01}, e1:{8'h75, 2'b11}, bat:0, err:0};
        tbl[2] = '{b:{8'hFA, 8'hEE, 8'hFE, 40'h0}, n:3, cnt:0, e0:10'h0, e1:10'h0, bat:0, err:0};
        tbl[3] = '{b:{8'hAA, 56'h0}, n:1, cnt:0, e0:10'h0, e1:10'h0, bat:1, err:0};
        tbl[4] = '{b:{8'h00, 8'hFF, 8'hFC, 40'h0}, n:3, cnt:0, e0:10'h0, e1:10'h0, bat:0, err:3};
        tbl[5] = '{b:{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77}, n:8, cnt:1, e0:{8'hE1, 2'b01}, e1:10'h0, bat:0, err:0};
`ifdef PS2_FAKE_SHIFT_FILTER_EN
        tbl[6] = '{b:{8'hE0, 8'h12, 8'hE0, 8'h7C, 32'h0}, n:4, cnt:1, e0:{8'h7C, 2'b01}, e1:10'h0, bat:0, err:0};
`else
        tbl[6] = '{b:{8'hE0, 8'h12, 8'hE0, 8'h7C, 32'h0}, n:4, cnt:2, e0:{8'h12, 2'b01}, e1:{8'h7C, 2'b01}, bat:0, err:0};
`endif
        tbl[7] = '{b:{8'hF0, 8'h00, 48'h0}, n:2, cnt:0, e0:10'h0, e1:10'h0, bat:0, err:1};
        tbl[8] = '{b:{8'hE0, 8'hF0, 8'hFF, 40'h0}, n:3, cnt:0, e0:10'h0, e1:10'h0, bat:0, err:1};
        tbl[9] = '{b:{8'hE0, 8'hAA, 48'h0}, n:2, cnt:1, e0:{8'hAA, 2'b01}, e1:10'h0, bat:0, err:0};

        #2;
        do_reset();

        // Strobe-to-visibility latency
        chk("lat_pre", 32'(evt_valid), 32'd0);
        byte_in = 8'h1C; byte_valid = 1'b1;
        cycle();
        byte_valid = 1'b0;
        chk("lat_valid", 32'(evt_valid), 32'd1);
        chk("lat_head", 32'({evt_code, evt_break, evt_ext}), 32'({8'h1C, 2'b00}));

        for (int k = 0; k < 10; k++) begin
            drain();
            bat_seen = 0; err_seen = 0;
            for (int i = 0; i < tbl[k].n; i++) send_byte(tbl[k].b[63-8*i -: 8]);
            repeat (2) cycle();
            chk($sformatf("v%0d_count", k), 32'(evt_count), 32'(tbl[k].cnt));
            if (tbl[k].cnt >= 1) chk($sformatf("v%0d_head0", k), 32'({evt_code, evt_break, evt_ext}), 32'(tbl[k].e0));
            if (tbl[k].cnt >= 2) begin
                evt_ready = 1'b1; cycle(); evt_ready = 1'b0;
                chk($sformatf("v%0d_head1", k), 32'({evt_code, evt_break, evt_ext}), 32'(tbl[k].e1));
            end
            chk($sformatf("v%0d_bat", k), 32'(bat_seen), 32'(tbl[k].bat));
            chk($sformatf("v%0d_err", k), 32'(err_seen), 32'(tbl[k].err));
        end

        // Overflow, set-wins, push+pop while full, clear
        drain();
        for (int i = 1; i <= 9; i++) send_byte(8'(i));
        chk("ovf_count", 32'(evt_count), 32'(DEPTH));
        chk("ovf_flag", 32'(overflow), 32'd1);
        chk("ovf_head", 32'({evt_code, evt_break, evt_ext}), 32'({8'h01, 2'b00}));
        ovf_clr = 1'b1; cycle(); ovf_clr = 1'b0;
        chk("ovf_clr1", 32'(overflow), 32'd0);
        ovf_clr = 1'b1; byte_in = 8'h0B; byte_valid = 1'b1; cycle();
        ovf_clr = 1'b0; byte_valid = 1'b0;
        chk("ovf_set_wins", 32'(overflow), 32'd1);
        chk("ovf_cnt2", 32'(evt_count), 32'(DEPTH));
        evt_ready = 1'b1; byte_in = 8'h0A; byte_valid = 1'b1; cycle();
        evt_ready = 1'b0; byte_valid = 1'b0;
        chk("full_pp_count", 32'(evt_count), 32'(DEPTH));
        chk("full_pp_head", 32'(evt_code), 32'h02);
        ovf_clr = 1'b1; cycle(); ovf_clr = 1'b0;
        chk("ovf_clr2", 32'(overflow), 32'd0);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("order%0d", i), 32'({evt_valid, evt_code}), 32'({1'b1, exp_codes[i]}));
            evt_ready = 1'b1; cycle(); evt_ready = 1'b0;
        end
        chk("order_empty", 32'(evt_valid), 32'd0);

        // Prefix timeout: exactly TMO idle cycles aborts, TMO-1 does not
        drain();
        byte_in = 8'hE0; byte_valid = 1'b1; cycle(); byte_valid = 1'b0;
        repeat (TMO) cycle();
        byte_in = 8'h1C; byte_valid = 1'b1; cycle(); byte_valid = 1'b0;
        chk("tmo_abort", 32'({evt_count, evt_code, evt_break, evt_ext}), 32'({CW'(1), 8'h1C, 2'b00}));
        drain();
        byte_in = 8'hE0; byte_valid = 1'b1; cycle(); byte_valid = 1'b0;
        repeat (TMO - 1) cycle();
        byte_in = 8'h1C; byte_valid = 1'b1; cycle(); byte_valid = 1'b0;
        chk("tmo_keep", 32'({evt_count, evt_code, evt_break, evt_ext}), 32'({CW'(1), 8'h1C, 2'b01}));

        // Reset in the middle of a break prefix
        drain();
        send_byte(8'h33);
        send_byte(8'hF0);
        chk("pre_rst_valid", 32'(evt_valid), 32'd1);
        do_reset();
        send_byte(8'h1C);
        chk("post_rst", 32'({evt_count, evt_code, evt_break, evt_ext}), 32'({CW'(1), 8'h1C, 2'b00}));

        // Randomized traffic against the reference model
        drain();
        rnd_chk = 1'b1;
        stall = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            if (c % 150 == 0) stall = ~stall;
            evt_ready = stall ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 1) == 1);
            ovf_clr = ($urandom_range(0, 30) == 0);
            if ($urandom_range(0, 60) == 0) begin
                byte_valid = 1'b0;
                repeat (TMO - 1 + $urandom_range(0, 2)) cycle();
            end
            byte_valid = ($urandom_range(0, 1) == 1);
            if ($urandom_range(0, 2) == 0) byte_in = 8'($urandom_range(0, 255));
            else byte_in = pool[$urandom_range(0, 12)];
            cycle();
        end
        rnd_chk = 1'b0;
        byte_valid = 1'b0; evt_ready = 1'b0; ovf_clr = 1'b0;

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule

// File: doc/ps2_scancode_decoder.md
Name: ps2_scancode_decoder

Overview:
- Downstream consumer of the PS/2 byte receiver.
- Takes validated scan-code-set-2 bytes (one-cycle strobe per byte), strips the E0/F0/E1 prefixes and removes controller status bytes.
- Queues key events in a small FIFO with a valid/ready output for the 68k-side bus interface.
- Single clock domain. The input byte strobe is already synchronous to clk.

Parameters:
- DEPTH, 8: FIFO entries. Power of two, minimum 2.
- TIMEOUT_CYCLES, 65535: idle cycles allowed inside a prefix sequence before the decoder aborts back to IDLE.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- byte_in  input  8  received scan byte.
- byte_valid  input  1  one-cycle strobe, byte_in valid.
- evt_code  output  8  head-of-FIFO key code.
- evt_break  output  1  head event is a release (F0 seen).
- evt_ext  output  1  head event is extended (E0 seen, or Pause).
- evt_valid  output  1  FIFO not empty.
- evt_ready  input  1  consumer accepts the head event this cycle.
- evt_count  output  $clog2(DEPTH)+1  number of entries held.
- overflow  output  1  sticky flag: an event was dropped.
- ovf_clr  input  1  clears overflow.
- bat_ok  output  1  one-cycle pulse on 0xAA received in IDLE.
- kbd_err  output  1  one-cycle pulse on 0x00, 0xFF or 0xFC.

Behaviour:
- Reset (async, rst_n low):
  - state=IDLE, FIFO empty, evt_valid=0, evt_code=0, evt_break=0, evt_ext=0, evt_count=0.
  - overflow=0, bat_ok=0, kbd_err=0, timeout counter=0.
  - Reset mid-sequence discards any partial prefix.
- The decoder acts only on cycles with byte_valid=1.
- States and transitions:
  - IDLE:
    - E0 -> GOT_E0; F0 -> GOT_F0; E1 -> PAUSE with skip=7.
    - 0xAA -> pulse bat_ok. 0x00/0xFF/0xFC -> pulse kbd_err. 0xFA/0xEE/0xFE -> dropped.
    - Any other byte -> push {code, break=0, ext=0}.
  - GOT_E0: F0 -> GOT_E0F0; 0x00/0xFF -> kbd_err, go to IDLE; other -> push {code, 0, 1}, go to IDLE.
  - GOT_F0: 0x00/0xFF -> kbd_err, go to IDLE; other -> push {code, 1, 0}, go to IDLE.
  - GOT_E0F0: 0x00/0xFF -> kbd_err, go to IDLE; other -> push {code, 1, 1}, go to IDLE.
  - PAUSE: each byte decrements skip and is discarded. On the 7th byte, push {0xE1, 0, 1} and go to IDLE.
- Timeout:
  - In any non-IDLE state, the counter increments on each cycle without byte_valid and clears on each byte.
  - When the counter reaches TIMEOUT_CYCLES, go to IDLE with nothing pushed and no pulse.
  - The counter is held at 0 in IDLE.
- FIFO (first-word fall-through):
  - The pushed event is written at the clock edge of its completing byte. evt_valid rises the next cycle if the FIFO was empty, so latency is 1 cycle from strobe to visibility.
  - Pop occurs when evt_valid and evt_ready are both high. The next entry, or empty, is visible the following cycle.
  - evt_code/evt_break/evt_ext hold their last value when empty; consumers qualify with evt_valid.
  - Push and pop in the same cycle: both take effect and count is unchanged. This holds even when the FIFO is full.
  - Push when full with no pop: the new event is dropped, FIFO contents are untouched and overflow is set.
  - Pointers wrap modulo DEPTH. evt_count ranges 0..DEPTH.
- overflow:
  - Stays set until ovf_clr=1.
  - If ovf_clr and a new drop happen in the same cycle, the set wins.
- Pulses: bat_ok and kbd_err are registered and high for exactly one cycle per triggering byte.

Optional Feature:
- Macro PS2_FAKE_SHIFT_FILTER_EN.
- Defined: events with ext=1 and code 0x12 or 0x59 (fake shifts inside E0 sequences) are discarded rather than pushed. They have no FIFO effect and no overflow effect, and the state still returns to IDLE.
- Undefined: these events are pushed like any other extended code.

Test Plan:
- Bytes 1C, F0 1C -> FIFO pops {1C,0,0} then {1C,1,0}; evt_valid rises 1 cycle after the 0x1C strobe.
- Bytes E0 75, E0 F0 75 -> {75,0,1} then {75,1,1}. Bytes FA, EE -> no events. Byte AA -> one-cycle bat_ok.
- Bytes E1 14 77 E1 F0 14 F0 77 -> exactly one event {E1,0,1}; FIFO count=1.
- evt_ready=0, push DEPTH+1 make codes 0x01..0x09 -> count=8, overflow=1, head=0x01, 0x09 absent. Then push and pop in the same cycle while full -> count stays 8, new code at the tail. ovf_clr -> overflow=0.
- Byte E0, then TIMEOUT_CYCLES idle cycles, then 0x1C -> {1C,0,0} (prefix aborted). Byte F0, then rst_n low mid-sequence -> all outputs at reset values, no event.
- With PS2_FAKE_SHIFT_FILTER_EN: E0 12 E0 7C -> only {7C,0,1}. Without the macro -> {12,0,1} then {7C,0,1}.
